// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART_TX serializer among g_Num_Req byte producers. A pending
// requester is picked, its byte is latched and a single-cycle DV strobe is
// issued. The serializer has no busy/done output, so the arbiter times each
// frame itself and only issues again once the serializer must be idle.
//
// Build option: define UART_TX_ARBITER_FIXED_PRIO_EN to replace round-robin
// selection with fixed priority (lowest set index always wins).
module uart_tx_arbiter #(
   parameter int g_Num_Req      = 4,
   parameter int g_Clks_Per_Bit = 217,
   parameter int g_Gap_Clks     = 0
) (
   input  logic                         i_Clk,
   input  logic                         i_Rst_n,
   input  logic [g_Num_Req-1:0]         i_Req_DV,
   input  logic [8*g_Num_Req-1:0]       i_Req_Data,
   output logic [g_Num_Req-1:0]         o_Req_Ack,
   output logic                         o_TX_DV,
   output logic [7:0]                   o_TX_Byte,
   output logic [$clog2(g_Num_Req)-1:0] o_Grant_Idx,
   output logic                         o_Busy
);

   localparam int IDX_W = $clog2(g_Num_Req);
   // Serializer DV-to-idle time plus the configured idle gap.
   localparam int FRAME = 10 * g_Clks_Per_Bit + 2 + g_Gap_Clks;
   localparam int CNT_W = $clog2(FRAME + 1);

   localparam logic [CNT_W-1:0] CNT_FRAME  = CNT_W'(FRAME);
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FRAME - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(g_Num_Req - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 tx_dv_q, tx_dv_d;
   logic [g_Num_Req-1:0] ack_q, ack_d;
   logic [7:0]           byte_q, byte_d;
   logic [IDX_W-1:0]     grant_q, grant_d;
   logic                 busy_q, busy_d;

   logic                 sel_found_s;
   logic [IDX_W-1:0]     sel_idx_s;
   logic [IDX_W-1:0]     cand_s;
   logic [7:0]           req_byte_s [g_Num_Req];

   for (genvar g = 0; g < g_Num_Req; g++) begin : g_unpack
      assign req_byte_s[g] = i_Req_Data[8*g +: 8];
   end

   // Pick the winning requester among those currently pending.
   always_comb begin
      sel_found_s = 1'b0;
      sel_idx_s   = '0;
      cand_s      = '0;
      for (int k = 0; k < g_Num_Req; k++) begin
`ifdef UART_TX_ARBITER_FIXED_PRIO_EN
         // Lowest index first; the last grant plays no part.
         cand_s = IDX_W'(k);
`else
         // Search upward from the slot after the last grant, wrapping.
         if ((int'(grant_q) + 1 + k) >= g_Num_Req) begin
            cand_s = IDX_W'(int'(grant_q) + 1 + k - g_Num_Req);
         end else begin
            cand_s = IDX_W'(int'(grant_q) + 1 + k);
         end
`endif
         if (!sel_found_s && i_Req_DV[cand_s]) begin
            sel_found_s = 1'b1;
            sel_idx_s   = cand_s;
         end else begin
            sel_found_s = sel_found_s;
            sel_idx_s   = sel_idx_s;
         end
      end
   end

   // Next-state and next-output logic; outputs are computed one cycle ahead
   // so every port is driven straight from a flop.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tx_dv_d = 1'b0;
      ack_d   = '0;
      byte_d  = byte_q;
      grant_d = grant_q;
      case (state_q)
         ST_IDLE: begin
            if (sel_found_s) begin
               state_d          = ST_ISSUE;
               tx_dv_d          = 1'b1;
               ack_d[sel_idx_s] = 1'b1;
               byte_d           = req_byte_s[sel_idx_s];
               grant_d          = sel_idx_s;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
            cnt_d   = CNT_RELOAD;
         end
         ST_WAIT: begin
            // Requests are not looked at until the frame time has elapsed.
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: begin
            // Unknown encoding: assume a frame may be in flight and wait it out.
            state_d = ST_WAIT;
            cnt_d   = CNT_FRAME;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers. Reset parks in WAIT for a full frame because
   // the serializer keeps running through our reset.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q <= ST_WAIT;
         cnt_q   <= CNT_FRAME;
         tx_dv_q <= 1'b0;
         ack_q   <= '0;
         byte_q  <= 8'h00;
         grant_q <= IDX_LAST;
         busy_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tx_dv_q <= tx_dv_d;
         ack_q   <= ack_d;
         byte_q  <= byte_d;
         grant_q <= grant_d;
         busy_q  <= busy_d;
      end
   end

   assign o_Req_Ack   = ack_q;
   assign o_TX_DV     = tx_dv_q;
   assign o_TX_Byte   = byte_q;
   assign o_Grant_Idx = grant_q;
   assign o_Busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Scoreboard bench for uart_tx_arbiter with a behavioural serializer and a
// serial-line decoder. Expected grants are queued when requests are driven and
// compared when the arbiter strobes o_TX_DV.
module tb_uart_tx_arbiter;

   localparam int NREQ   = 4;
   localparam int CPB    = 4;
   localparam int GAP    = 0;
   localparam int FRAME  = 10 * CPB + 2 + GAP;
   localparam int PERIOD = FRAME + 2;

   typedef struct {
      logic [7:0] b;
      int         idx;
      int         at;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic [NREQ-1:0]   req = '0;
   logic [7:0]        rdata [NREQ];
   logic [8*NREQ-1:0] req_data;
   logic [NREQ-1:0]   ack;
   logic              tx_dv;
   logic [7:0]        tx_byte;
   logic [1:0]        grant;
   logic              busy;

   int                n_vec = 0;
   int                n_err = 0;
   int                cyc = 0;
   int                last_dv = 0;
   int                ack2_cnt = 0;
   int                dv_busy_cnt = 0;
   logic [NREQ-1:0]   prev_req = '0;
   logic [NREQ-1:0]   auto_drop = '1;

   exp_t              sb[$];
   logic [7:0]        rxq[$];

   // serializer model and line decoder state
   logic              ser_act = 1'b0;
   int                ser_el = 0;
   logic [9:0]        ser_frame = '1;
   logic              tx_line;
   logic              rx_act = 1'b0;
   int                rx_t = 0;
   logic [7:0]        rx_sh = '0;

   assign req_data = {rdata[3], rdata[2], rdata[1], rdata[0]};

   uart_tx_arbiter #(
      .g_Num_Req      (NREQ),
      .g_Clks_Per_Bit (CPB),
      .g_Gap_Clks     (GAP)
   ) dut (
      .i_Clk       (clk),
      .i_Rst_n     (rst_n),
      .i_Req_DV    (req),
      .i_Req_Data  (req_data),
      .o_Req_Ack   (ack),
      .o_TX_DV     (tx_dv),
      .o_TX_Byte   (tx_byte),
      .o_Grant_Idx (grant),
      .o_Busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic expect_grant(input logic [7:0] b, input int idx, input int at);
      exp_t e;
      e.b   = b;
      e.idx = idx;
      e.at  = at;
      sb.push_back(e);
      rxq.push_back(b);
   endtask

   task automatic monitor();
      exp_t            e;
      logic [NREQ-1:0] exp_ack;
      if (ack != '0) begin
         check_val("ack_to_idle_req", 32'(ack & ~prev_req), 32'd0);
         check_val("ack_without_dv", 32'(tx_dv), 32'd1);
      end
      if (ack[2]) ack2_cnt++;
      if (tx_dv) begin
         last_dv = cyc;
         if (sb.size() == 0) begin
            check_val("unexpected_dv", 32'(sb.size()), 32'd1);
         end else begin
            e = sb.pop_front();
            exp_ack = NREQ'(1) << e.idx;
            check_val("tx_byte", 32'(tx_byte), 32'(e.b));
            check_val("ack_onehot", 32'(ack), 32'(exp_ack));
            check_val("grant_idx", 32'(grant), 32'(e.idx));
            check_val("dv_cycle", 32'(cyc), 32'(e.at));
         end
      end
      // requesters that release on ack drop their request in the following cycle
      req = req & ~(ack & auto_drop);
   endtask

   task automatic tick();
      prev_req = req;
      @(posedge clk);
      #1;
      cyc++;
      monitor();
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (sb.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      check_val("sb_drain", 32'(sb.size()), 32'd0);
   endtask

   task automatic check_reset_outs(input string ph);
      check_val({ph, "_dv"},    32'(tx_dv),   32'd0);
      check_val({ph, "_ack"},   32'(ack),     32'd0);
      check_val({ph, "_byte"},  32'(tx_byte), 32'd0);
      check_val({ph, "_grant"}, 32'(grant),   32'(NREQ - 1));
      check_val({ph, "_busy"},  32'(busy),    32'd1);
   endtask

   task automatic rx_check(input logic stop_bit);
      check_val("rx_stop_bit", 32'(stop_bit), 32'd1);
      if (rxq.size() == 0) begin
         check_val("rx_unexpected", 32'(rxq.size()), 32'd1);
      end else begin
         check_val("rx_byte", 32'(rx_sh), 32'(rxq.pop_front()));
      end
   endtask

   // Behavioural UART_TX: start, 8 data LSB first, stop, one cleanup cycle.
   always @(posedge clk) begin
      if (!ser_act) begin
         if (tx_dv) begin
            ser_act   <= 1'b1;
            ser_el    <= 0;
            ser_frame <= {1'b1, tx_byte, 1'b0};
         end
      end else begin
         if (tx_dv) dv_busy_cnt <= dv_busy_cnt + 1;
         if (ser_el == 10 * CPB) ser_act <= 1'b0;
         else ser_el <= ser_el + 1;
      end
   end

   assign tx_line = (ser_act && ser_el < 10 * CPB) ? ser_frame[4'(ser_el / CPB)] : 1'b1;

   // Serial-line decoder sampling mid-bit.
   always @(posedge clk) begin
      if (!rx_act) begin
         if (!tx_line) begin
            rx_act <= 1'b1;
            rx_t   <= 1;
         end
      end else begin
         rx_t <= rx_t + 1;
         if ((rx_t % CPB) == (CPB / 2)) begin
            if ((rx_t / CPB) >= 1 && (rx_t / CPB) <= 8) begin
               rx_sh <= {tx_line, rx_sh[7:1]};
            end else if ((rx_t / CPB) == 9) begin
               rx_act <= 1'b0;
               rx_check(tx_line);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < NREQ; k++) rdata[k] = 8'h00;
      rdata[0]  = 8'h5A;
      req       = 4'b0001;
      auto_drop = '1;
      #1;
      rst_n = 1'b0;
      #1;
      check_reset_outs("rst0");
      repeat (3) tick();
      check_reset_outs("rst1");

      // first issue after reset comes one full frame plus two cycles later
      rst_n = 1'b1;
      expect_grant(8'h5A, 0, cyc + PERIOD);
      wait_drain(PERIOD + 10);

      // requester 2 raises and drops its request entirely inside WAIT
      repeat (5) tick();
      ack2_cnt = 0;
      rdata[2] = 8'h77;
      req[2]   = 1'b1;
      repeat (10) tick();
      req[2] = 1'b0;
      while (cyc < last_dv + FRAME) tick();
      check_val("busy_end_of_wait", 32'(busy), 32'd1);
      tick();
      check_val("busy_in_idle", 32'(busy), 32'd0);
      repeat (10) tick();
      check_val("dropped_req_no_ack", 32'(ack2_cnt), 32'd0);

      // two bytes back-to-back through the serializer
      rdata[1] = 8'h55;
      rdata[2] = 8'hC3;
      req      = 4'b0110;
      expect_grant(8'h55, 1, cyc + 1);
      expect_grant(8'hC3, 2, cyc + 1 + PERIOD);
      wait_drain(2 * PERIOD + 10);

      // reset in the middle of a frame
      repeat (10) tick();
      rst_n = 1'b0;
      #1;
      check_reset_outs("rst_mid");
      repeat (3) tick();
      check_reset_outs("rst_hold");

      // continuous requests after release
      auto_drop = '0;
      for (int k = 0; k < NREQ; k++) rdata[k] = 8'hA0 + 8'(k);
`ifdef UART_TX_ARBITER_FIXED_PRIO_EN
      req = 4'b1010;
`else
      req = 4'b1111;
`endif
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
`ifdef UART_TX_ARBITER_FIXED_PRIO_EN
         expect_grant(8'hA1, 1, cyc + PERIOD * (k + 1));
`else
         expect_grant(8'hA0 + 8'(k % NREQ), k % NREQ, cyc + PERIOD * (k + 1));
`endif
      end
      wait_drain(6 * PERIOD);
      req = '0;

      repeat (60) tick();
      check_val("rx_drain", 32'(rxq.size()), 32'd0);
      check_val("dv_while_ser_busy", 32'(dv_busy_cnt), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART_TX serializer among g_Num_Req byte producers, e.g. a debug console, a status reporter and a VGA frame-info dumper.
- Selects one pending requester using round-robin, latches its byte and issues a single-cycle DV strobe to the serializer.
- The serializer has no busy or done output, so the arbiter times each frame itself and holds off the next strobe until the serializer is idle again.

Parameters:
- g_Num_Req, 4: number of requesters; legal range 2..8.
- g_Clks_Per_Bit, 217: must match the serializer's clocks per bit (25 MHz / 115200).
- g_Gap_Clks, 0: extra idle clocks inserted after each frame.

Ports:
- i_Clk  in  1  system clock, rising edge.
- i_Rst_n  in  1  asynchronous active-low reset.
- i_Req_DV  in  g_Num_Req  per-requester level request; held high until acknowledged.
- i_Req_Data  in  8*g_Num_Req  requester k's byte on bits [8k+7:8k]; stable while its i_Req_DV is high.
- o_Req_Ack  out  g_Num_Req  one-hot single-cycle pulse; the byte has been taken.
- o_TX_DV  out  1  to serializer i_TX_DV; single-cycle strobe.
- o_TX_Byte  out  8  to serializer i_Data_Byte; valid while o_TX_DV is high, held afterwards.
- o_Grant_Idx  out  clog2(g_Num_Req)  index of the last granted requester.
- o_Busy  out  1  high in every state except IDLE.

Behaviour:
- Frame time: FRAME = 10*g_Clks_Per_Bit + 2 + g_Gap_Clks. This equals the serializer's DV-to-idle time plus the gap.
- Counter width is clog2(FRAME+1).
- All outputs are registered.
- Reset values:
  - o_TX_DV = 0, o_Req_Ack = 0, o_TX_Byte = 0.
  - o_Grant_Idx = g_Num_Req-1, so requester 0 wins first.
  - o_Busy = 1.
  - State = WAIT with counter = FRAME.
- Reset handling: the serializer itself is not reset, so after reset the arbiter always waits one full frame before its first issue. This covers reset asserted mid-frame.
- IDLE:
  - If i_Req_DV is nonzero, select the first set bit searching from o_Grant_Idx+1 upward, wrapping modulo g_Num_Req.
  - Latch that requester's byte into o_TX_Byte, update o_Grant_Idx, go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle):
  - o_TX_DV = 1 and o_Req_Ack[o_Grant_Idx] = 1.
  - Load counter = FRAME - 1, go to WAIT.
- WAIT:
  - Decrement the counter each cycle; when the counter is 0, go to IDLE.
  - Requests are ignored while in WAIT.
- Timing:
  - Request seen in IDLE to o_TX_DV is 1 cycle.
  - With continuous requests, consecutive o_TX_DV pulses are exactly FRAME+2 cycles apart.
- Handshake:
  - The requester may drop i_Req_DV or present a new byte on the cycle after its ack.
  - A request dropped before ack is simply never served; no partial state remains.
  - Ack is never asserted to a requester whose i_Req_DV was low in the selecting IDLE cycle.
- Round-robin fairness: with all requesters pending, grants rotate 0,1,…,N-1,0. No requester waits more than N-1 frames.
- Simultaneous events: a new request arriving in the same cycle as a WAIT→IDLE transition is evaluated in the following IDLE cycle.
- An unused state encoding returns to WAIT with counter = FRAME.

Optional Feature:
- Macro: UART_TX_ARBITER_FIXED_PRIO_EN
- Defined: fixed priority, lowest set index always wins. o_Grant_Idx still reports the winner, but it no longer influences selection.
- Undefined: round-robin as described above.

Test Plan:
- Reset release, CPB=4, gap=0 (FRAME=42), i_Req_DV=4'b0001 held from reset → first o_TX_DV exactly 44 cycles after deassertion; o_Req_Ack=4'b0001 in the same cycle; o_TX_Byte = requester 0's byte.
- All four requesting, bytes 0xA0..0xA3, continuous → o_TX_DV every 44 cycles; bytes in order A0,A1,A2,A3,A0; acks one-hot, matching the byte.
- Serializer instance in the bench: send 0x55 then 0xC3 back-to-back → decoded serial stream shows both bytes intact; no DV is seen while the serializer is not in Idle.
- Requester 2 raises then drops i_Req_DV during WAIT → no ack and no DV for requester 2.
- Assert i_Rst_n low for 3 cycles mid-frame → outputs at reset values immediately (asynchronously); next DV no sooner than FRAME+2 cycles after release.
- With UART_TX_ARBITER_FIXED_PRIO_EN defined, requesters 1 and 3 held continuously → every grant goes to 1; 3 never acked.
